// File: rtl/video_led_seq_if.sv
// Control and pattern bus of the frame-synchronous LED sequencer.
// The master drives the enable, frame strobe, mode, speed and host pattern.
// The slave (the sequencer) returns the LED vector and the step pulse.
interface video_led_seq_if #(
    parameter int C_LED_N = 18,
    parameter int C_SPD_W = 4
);
    logic               ck_ee;
    logic               frame_stb;
    logic [1:0]         mode;
    logic [C_SPD_W-1:0] speed;
    logic [C_LED_N-1:0] host_leds;
    logic [C_LED_N-1:0] leds_on;
    logic               step;

    modport master (
        output ck_ee, frame_stb, mode, speed, host_leds,
        input  leds_on, step
    );

    modport slave (
        input  ck_ee, frame_stb, mode, speed, host_leds,
        output leds_on, step
    );
endinterface

// File: rtl/video_led_seq.sv
// Frame-synchronous LED pattern sequencer feeding the LED hit judge.
// Produces host / chase / blink / bar patterns and steps once every
// (speed+1) frames. The pattern only moves on an enabled frame strobe,
// so the judge never sees a change in the middle of a field.
// Build option: define VIDEO_LED_SEQ_BOUNCE_EN to make CHASE ping-pong
// instead of wrapping from the top LED back to LED 0.
//
// Bar FSM states:
//   state      | meaning
//   BAR_FILL   | level grows by one per step until all LEDs are lit
//   BAR_DRAIN  | level shrinks by one per step until no LED is lit
module video_led_seq #(
    parameter int C_LED_N = 18,
    parameter int C_SPD_W = 4
) (
    input logic             clk,
    input logic             rst_n,
    video_led_seq_if.slave  bus
);
    localparam int PTR_W = (C_LED_N > 1) ? $clog2(C_LED_N) : 1;
    localparam int LVL_W = $clog2(C_LED_N + 1);

    localparam logic [1:0] M_HOST  = 2'd0;
    localparam logic [1:0] M_CHASE = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_BAR   = 2'd3;

    localparam logic [0:0] BAR_FILL  = 1'b0;
    localparam logic [0:0] BAR_DRAIN = 1'b1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(C_LED_N - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(C_LED_N);
    localparam logic [C_LED_N-1:0] CH_ONE = C_LED_N'(1);
    localparam logic [C_LED_N:0]   BAR_ONE = (C_LED_N + 1)'(1);

    logic [C_SPD_W-1:0] fctr;
    logic [1:0]         mode_q;
    logic [PTR_W-1:0]   ptr;
    logic               blk;
    logic [LVL_W-1:0]   level;
    logic [0:0]         bar_st;
    logic [C_LED_N-1:0] leds_q;
    logic               step_q;

    logic [PTR_W-1:0]   ptr_step;
    logic [LVL_W-1:0]   level_step;
    logic [0:0]         bar_step;

`ifdef VIDEO_LED_SEQ_BOUNCE_EN
    logic dir;
    logic dir_step;
`endif

    function automatic logic [C_LED_N-1:0] chase_pat(input logic [PTR_W-1:0] p);
        return CH_ONE << p;
    endfunction

    // Low 'lvl' LEDs lit; computed one bit wider so lvl==C_LED_N yields all ones.
    function automatic logic [C_LED_N-1:0] bar_pat(input logic [LVL_W-1:0] lvl);
        logic [C_LED_N:0] t;
        t = (BAR_ONE << lvl) - BAR_ONE;
        return t[C_LED_N-1:0];
    endfunction

    // Next chase pointer and bar level/state, used only when a step is taken.
    always_comb begin
        ptr_step   = ptr;
        level_step = level;
        bar_step   = bar_st;
`ifdef VIDEO_LED_SEQ_BOUNCE_EN
        dir_step = dir;
        if (!dir) begin
            if (ptr == PTR_LAST) begin
                dir_step = 1'b1;
                ptr_step = PTR_W'(C_LED_N - 2);
            end else begin
                ptr_step = ptr + PTR_W'(1);
            end
        end else begin
            if (ptr == '0) begin
                dir_step = 1'b0;
                ptr_step = PTR_W'(1);
            end else begin
                ptr_step = ptr - PTR_W'(1);
            end
        end
`else
        ptr_step = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
`endif
        if (bar_st == BAR_FILL) begin
            if (level == LVL_FULL) begin
                bar_step   = BAR_DRAIN;
                level_step = LVL_W'(C_LED_N - 1);
            end else begin
                level_step = level + LVL_W'(1);
            end
        end else begin
            if (level == '0) begin
                bar_step   = BAR_FILL;
                level_step = LVL_W'(1);
            end else begin
                level_step = level - LVL_W'(1);
            end
        end
    end

    // Frame-strobe sequencing: mode change, step, or frame count, all gated by ck_ee.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fctr   <= '0;
            mode_q <= M_HOST;
            ptr    <= '0;
            blk    <= 1'b0;
            level  <= '0;
            bar_st <= BAR_FILL;
            leds_q <= '0;
            step_q <= 1'b0;
`ifdef VIDEO_LED_SEQ_BOUNCE_EN
            dir    <= 1'b0;
`endif
        end else if (bus.ck_ee) begin
            step_q <= 1'b0;
            if (bus.frame_stb) begin
                if (bus.mode != mode_q) begin
                    mode_q <= bus.mode;
                    fctr   <= '0;
                    ptr    <= '0;
                    blk    <= 1'b1;
                    level  <= '0;
                    bar_st <= BAR_FILL;
`ifdef VIDEO_LED_SEQ_BOUNCE_EN
                    dir    <= 1'b0;
`endif
                    unique case (bus.mode)
                        M_HOST:  leds_q <= bus.host_leds;
                        M_CHASE: leds_q <= CH_ONE;
                        M_BLINK: leds_q <= '1;
                        M_BAR:   leds_q <= '0;
                    endcase
                end else begin
                    // >= lets a lowered speed take effect on the very next frame.
                    if (fctr >= bus.speed) begin
                        fctr   <= '0;
                        step_q <= 1'b1;
                        unique case (mode_q)
                            M_HOST: ;
                            M_CHASE: begin
                                ptr    <= ptr_step;
                                leds_q <= chase_pat(ptr_step);
`ifdef VIDEO_LED_SEQ_BOUNCE_EN
                                dir    <= dir_step;
`endif
                            end
                            M_BLINK: begin
                                blk    <= ~blk;
                                leds_q <= {C_LED_N{~blk}};
                            end
                            M_BAR: begin
                                level  <= level_step;
                                bar_st <= bar_step;
                                leds_q <= bar_pat(level_step);
                            end
                        endcase
                    end else if (fctr != '1) begin
                        fctr <= fctr + C_SPD_W'(1);
                    end
                    if (mode_q == M_HOST) begin
                        leds_q <= bus.host_leds;
                    end
                end
            end
        end
    end

    assign bus.leds_on = leds_q;
    assign bus.step    = step_q;
endmodule

// File: tb/tb_video_led_seq.sv
// Self-checking bench for video_led_seq: a behavioural model pushes the
// expected LED vector and step pulse for every driven cycle; the value is
// popped and compared just after the following clock edge.
module tb_video_led_seq;
    localparam int N  = 18;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    video_led_seq_if #(.C_LED_N(N), .C_SPD_W(SW)) bus ();

    video_led_seq #(.C_LED_N(N), .C_SPD_W(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [N-1:0] leds;
        logic         step;
    } exp_t;

    exp_t sb_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int step_cnt = 0;

    int           m_mode, m_fctr, m_phase, m_blk;
    logic [N-1:0] m_leds;
    logic         m_step;

`ifdef VIDEO_LED_SEQ_BOUNCE_EN
    localparam int CH_PERIOD = 2*N - 2;
    localparam logic [N-1:0] CH_AFTER_TOP = N'(1) << (N - 2);
`else
    localparam int CH_PERIOD = N;
    localparam logic [N-1:0] CH_AFTER_TOP = N'(1);
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] chase_leds(input int phase);
        int p;
        p = (phase < N) ? phase : (2*N - 2 - phase);
        return N'(1) << p;
    endfunction

    function automatic logic [N-1:0] bar_leds(input int phase);
        int lvl;
        logic [31:0] v;
        lvl = (phase <= N) ? phase : (2*N - phase);
        v = (32'd1 << lvl) - 32'd1;
        return v[N-1:0];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fctr = 0; m_phase = 0; m_blk = 0;
        m_leds = '0; m_step = 1'b0;
        sb_q.delete();
    endtask

    task automatic model_cycle(input logic ee, input logic stb);
        if (ee) begin
            m_step = 1'b0;
            if (stb) begin
                if (int'(bus.mode) != m_mode) begin
                    m_mode = int'(bus.mode);
                    m_fctr = 0; m_phase = 0; m_blk = 1;
                    case (m_mode)
                        0: m_leds = bus.host_leds;
                        1: m_leds = chase_leds(0);
                        2: m_leds = '1;
                        default: m_leds = '0;
                    endcase
                end else begin
                    if (m_fctr >= int'(bus.speed)) begin
                        m_fctr = 0;
                        m_step = 1'b1;
                        case (m_mode)
                            1: begin
                                m_phase = (m_phase + 1) % CH_PERIOD;
                                m_leds  = chase_leds(m_phase);
                            end
                            2: begin
                                m_blk  = 1 - m_blk;
                                m_leds = (m_blk != 0) ? '1 : '0;
                            end
                            3: begin
                                m_phase = (m_phase + 1) % (2*N);
                                m_leds  = bar_leds(m_phase);
                            end
                            default: ;
                        endcase
                    end else if (m_fctr < (1 << SW) - 1) begin
                        m_fctr++;
                    end
                    if (m_mode == 0) m_leds = bus.host_leds;
                end
            end
        end
        sb_q.push_back('{leds: m_leds, step: m_step});
    endtask

    task automatic cyc(input logic ee, input logic stb, input string tag);
        exp_t e;
        bus.ck_ee     = ee;
        bus.frame_stb = stb;
        model_cycle(ee, stb);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_leds"}, 32'(bus.leds_on), 32'(e.leds));
            chk({tag, "_step"}, 32'(bus.step), 32'(e.step));
        end
    endtask

    task automatic event_(input string tag);
        cyc(1'b1, 1'b1, tag);
        if (bus.step) step_cnt++;
        cyc(1'b1, 1'b0, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ck_ee = 1'b0; bus.frame_stb = 1'b0; bus.mode = 2'd0;
        bus.speed = '0; bus.host_leds = '0;
        model_reset();

        // T1: reset holds outputs low regardless of inputs.
        repeat (6) begin
            bus.ck_ee     = 1'($urandom_range(0, 1));
            bus.frame_stb = 1'($urandom_range(0, 1));
            bus.mode      = 2'($urandom_range(0, 3));
            bus.speed     = SW'($urandom_range(0, 15));
            bus.host_leds = N'($urandom);
            @(posedge clk); #1;
            chk("rst_leds", 32'(bus.leds_on), 32'd0);
            chk("rst_step", 32'(bus.step), 32'd0);
        end
        bus.ck_ee = 1'b1; bus.frame_stb = 1'b0; bus.mode = 2'd0;
        bus.speed = '0; bus.host_leds = N'(18'h3FFFF);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (3) cyc(1'b1, 1'b0, "post_rst");

        // T2: host pattern loaded on an event, held without one.
        bus.host_leds = N'(18'h2A5A5);
        cyc(1'b1, 1'b1, "host_evt");
        chk("host_val", 32'(bus.leds_on), 32'h2A5A5);
        bus.host_leds = N'(18'h15A5A);
        repeat (3) cyc(1'b1, 1'b0, "host_hold");
        chk("host_hold_val", 32'(bus.leds_on), 32'h2A5A5);
        bus.speed = SW'(3);
        for (int i = 0; i < 6; i++) begin
            bus.host_leds = N'($urandom);
            event_("host_follow");
        end

        // T3: chase at speed 2 steps on every third event.
        bus.mode = 2'd1; bus.speed = SW'(2);
        event_("chase_sw");
        chk("chase_init", 32'(bus.leds_on), 32'h1);
        step_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            event_("chase");
            if (i == 3*17 - 1) chk("chase_top", 32'(bus.leds_on), 32'h20000);
            if (i == 3*18 - 1) chk("chase_after_top", 32'(bus.leds_on), 32'(CH_AFTER_TOP));
        end
        chk("chase_pulses", 32'(step_cnt), 32'd20);

        // T4: bar fills to N and drains to 0, each endpoint shown once.
        bus.mode = 2'd3; bus.speed = '0;
        event_("bar_sw");
        chk("bar_init_pop", 32'($countones(bus.leds_on)), 32'd0);
        for (int i = 1; i <= 2*N + 2; i++) begin
            int lvl;
            event_("bar");
            lvl = (i <= N) ? i : ((i <= 2*N) ? 2*N - i : i - 2*N);
            chk("bar_pop", 32'($countones(bus.leds_on)), 32'(lvl));
        end

        // T5: mode switch mid-chase, then a speed drop below the frame count.
        bus.mode = 2'd1; bus.speed = '0;
        event_("t5_chase_sw");
        repeat (5) event_("t5_chase");
        chk("t5_ptr5", 32'(bus.leds_on), 32'h20);
        bus.mode = 2'd2;
        cyc(1'b1, 1'b1, "t5_sw");
        chk("t5_all_ones", 32'(bus.leds_on), 32'h3FFFF);
        chk("t5_sw_step", 32'(bus.step), 32'd0);
        cyc(1'b1, 1'b0, "t5_sw");
        bus.speed = SW'(15);
        repeat (7) event_("t5_count");
        bus.speed = SW'(3);
        cyc(1'b1, 1'b1, "t5_drop");
        chk("t5_drop_step", 32'(bus.step), 32'd1);
        cyc(1'b1, 1'b0, "t5_drop");

        // T6: strobes ignored while disabled; step pulse frozen by ck_ee low.
        bus.speed = '0;
        repeat (4) cyc(1'b0, 1'b1, "ee_gate");
        cyc(1'b1, 1'b1, "ee_step");
        repeat (5) cyc(1'b0, 1'b0, "ee_freeze");
        chk("ee_step_hold", 32'(bus.step), 32'd1);
        cyc(1'b1, 1'b0, "ee_release");
        chk("ee_step_clear", 32'(bus.step), 32'd0);

        // Async reset mid-pattern, then first HOST event at speed 2 only counts.
        bus.mode = 2'd1;
        repeat (3) event_("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_leds", 32'(bus.leds_on), 32'd0);
        chk("async_rst_step", 32'(bus.step), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.mode = 2'd0; bus.speed = SW'(2); bus.host_leds = N'(18'h0F0F0);
        cyc(1'b1, 1'b1, "rst_host_evt");
        chk("rst_host_step", 32'(bus.step), 32'd0);
        cyc(1'b1, 1'b0, "rst_host_evt");
        repeat (4) event_("rst_host");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
